// File: rtl/zeroriscy_bnn_unit.sv
`default_nettype none
// ============================================================================
// Module   : zeroriscy_bnn_unit
// Purpose  : Multi-cycle EX-stage unit for the OPCODE_BNN (7'h0b) custom
//            instruction group. Keeps a private signed accumulator of
//            binarized (+1/-1) dot products and computes the xnor-popcount
//            of rs1/rs2 SLICE_W bits per cycle.
// Ports    : clk          core clock
//            rst_n        synchronous active-low reset
//            bnn_en_i     request from ID, held high until ready_o
//            bnn_op_i     00 XNORPOP, 01 CLR, 10 RDACC, 11 THRESH
//            operand_a_i  rs1 (activation bits, or threshold for THRESH)
//            operand_b_i  rs2 (weight bits)
//            result_o     result, valid while ready_o=1
//            ready_o      one-cycle completion pulse
//            busy_o       high while an operation is in flight
// Revision : 1.0 - initial release
// ============================================================================
module zeroriscy_bnn_unit #(
  parameter int ACC_WIDTH = 16,
  parameter int SLICE_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bnn_en_i,
  input  logic [1:0]  bnn_op_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        busy_o
);

  localparam int c_N_SLICES = 32 / SLICE_W;
  localparam int c_CNT_W    = (c_N_SLICES > 1) ? $clog2(c_N_SLICES) : 1;

  localparam logic [1:0] c_OP_XNORPOP = 2'b00;
  localparam logic [1:0] c_OP_CLR     = 2'b01;
  localparam logic [1:0] c_OP_RDACC   = 2'b10;
  localparam logic [1:0] c_OP_THRESH  = 2'b11;

  localparam logic [ACC_WIDTH-1:0] c_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] c_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // Elaboration-time parameter checks
  if ((32 % SLICE_W) != 0) begin : g_bad_slice_w
    $error("zeroriscy_bnn_unit: SLICE_W (%0d) must divide 32", SLICE_W);
  end
  if ((ACC_WIDTH < 8) || (ACC_WIDTH > 32)) begin : g_bad_acc_width
    $error("zeroriscy_bnn_unit: ACC_WIDTH (%0d) must be in 8..32", ACC_WIDTH);
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [ACC_WIDTH-1:0] w_acc_next;
  logic [31:0]          r_xn;
  logic [31:0]          w_xn_next;
  logic [5:0]           r_partial;
  logic [5:0]           w_partial_next;
  logic [c_CNT_W-1:0]   r_slice_cnt;
  logic [c_CNT_W-1:0]   w_slice_cnt_next;
  logic [31:0]          w_result_next;

  function automatic logic [5:0] popcnt(input logic [SLICE_W-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

  // --------------------------------------------------------------------------
  // Slice datapath
  // --------------------------------------------------------------------------
  logic [5:0]            w_shamt;
  logic [SLICE_W-1:0]    w_slice;
  logic [5:0]            w_partial_sum;
  logic                  w_last_slice;
  logic signed [7:0]     w_delta;
  logic [ACC_WIDTH+7:0]  w_sum;
  logic [8:0]            w_sum_hi;
  logic [ACC_WIDTH-1:0]  w_acc_sat;
  logic signed [31:0]    w_acc32;

  assign w_shamt       = 6'(32'(r_slice_cnt) * SLICE_W);
  assign w_slice       = SLICE_W'(r_xn >> w_shamt);
  assign w_partial_sum = r_partial + popcnt(w_slice);
  assign w_last_slice  = (r_slice_cnt == c_CNT_W'(c_N_SLICES - 1));

  // Each matching bit is +1, each mismatch -1: delta = 2*matches - 32
  assign w_delta = $signed({1'b0, w_partial_sum, 1'b0}) - 8'sd32;

  // Sum is computed 8 bits wider than the accumulator so it cannot wrap;
  // the top 9 bits all equal means the result fits in ACC_WIDTH bits.
  assign w_sum    = (ACC_WIDTH+8)'($signed(r_acc)) + (ACC_WIDTH+8)'(w_delta);
  assign w_sum_hi = w_sum[ACC_WIDTH+7:ACC_WIDTH-1];

  always_comb begin
    if ((w_sum_hi == 9'h000) || (w_sum_hi == 9'h1FF)) begin
      w_acc_sat = w_sum[ACC_WIDTH-1:0];
    end else if (w_sum[ACC_WIDTH+7]) begin
      w_acc_sat = c_ACC_MIN;
    end else begin
      w_acc_sat = c_ACC_MAX;
    end
  end

  assign w_acc32 = 32'($signed(r_acc));

  // --------------------------------------------------------------------------
  // FSM next-state and datapath next values
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next     = r_state;
    w_acc_next       = r_acc;
    w_xn_next        = r_xn;
    w_partial_next   = r_partial;
    w_slice_cnt_next = r_slice_cnt;
    w_result_next    = result_o;

    case (r_state)
      ST_IDLE: begin
        if (bnn_en_i) begin
          w_xn_next    = ~(operand_a_i ^ operand_b_i);
          w_state_next = ST_FINISH;
          case (bnn_op_i)
            c_OP_XNORPOP: begin
              w_state_next     = ST_CALC;
              w_partial_next   = '0;
              w_slice_cnt_next = '0;
            end
            c_OP_CLR: begin
              w_result_next = w_acc32;
              w_acc_next    = '0;
            end
            c_OP_RDACC: begin
              w_result_next = w_acc32;
            end
            c_OP_THRESH: begin
              w_result_next = {31'b0, (w_acc32 >= $signed(operand_a_i))};
              w_acc_next    = '0;
            end
            default: ;
          endcase
        end
      end

      ST_CALC: begin
        w_partial_next   = w_partial_sum;
        w_slice_cnt_next = r_slice_cnt + c_CNT_W'(1);
        if (w_last_slice) begin
          // Accumulator commits on entry to FINISH
          w_state_next  = ST_FINISH;
          w_acc_next    = w_acc_sat;
          w_result_next = 32'($signed(w_acc_sat));
        end
      end

      ST_FINISH: begin
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_xn        <= '0;
      r_partial   <= '0;
      r_slice_cnt <= '0;
      result_o    <= '0;
    end else begin
      r_state     <= w_state_next;
      r_acc       <= w_acc_next;
      r_xn        <= w_xn_next;
      r_partial   <= w_partial_next;
      r_slice_cnt <= w_slice_cnt_next;
      result_o    <= w_result_next;
    end
  end

  assign ready_o = (r_state == ST_FINISH);
  assign busy_o  = (r_state != ST_IDLE);

endmodule
`default_nettype wire
